csr_regs: RTL and testbench
===========================

CSR_REGS -- requirements
Module: csr_regs

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-003 SHALL have port csr_raddr_i, input, 12, CSR read address from id/ex.
REQ-004 SHALL have port csr_rdata_o, output, 64, combinational read data for csr_raddr_i.
REQ-005 SHALL have port csr_illegal_o, output, 1, asserted when csr_raddr_i is unimplemented.
REQ-006 SHALL have port csr_op_i, input, 2, instruction write op: 00 none, 01 RW, 10 RS (set), 11 RC (clear).
REQ-007 SHALL have port csr_waddr_i, input, 12, instruction write address.
REQ-008 SHALL have port csr_wdata_i, input, 64, instruction write operand (rs1 or zimm, zero-extended).
REQ-009 SHALL have port trap_wen_i, input, 1, trap/return update strobe from trap controller.
REQ-010 SHALL have ports trap_mepc_i, trap_mcause_i, trap_mstatus_i, input, 64 each, trap update values.
REQ-011 SHALL have ports mtvec_o, mepc_o, mstatus_o, output, 64 each, current register values to trap controller.
REQ-012 SHALL have port timer_irq_i, input, 1, level timer interrupt request.
REQ-013 SHALL have port irq_pending_o, output, 1, registered: mstatus.MIE & mie.MTIE & mip.MTIP.

Function
REQ-014 SHALL implement: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344 (read-only), mcycle 0xB00.
REQ-015 SHALL drive csr_rdata_o = 0 and csr_illegal_o = 1 for any other csr_raddr_i; csr_illegal_o = 0 otherwise.
REQ-016 SHALL compute new value as RW: wdata; RS: old | wdata; RC: old & ~wdata; applied at next edge when csr_op_i != 00.
REQ-017 SHALL apply write masks: mstatus writable bits 3 (MIE), 7 (MPIE), 12:11 (MPP), rest read 0; mie writable bit 7 only; mtvec[1:0] and mepc[1:0] forced 0; mcause, mscratch, mcycle full 64 bits.
REQ-018 SHALL ignore instruction writes to mip and to unimplemented addresses (no state change).
REQ-019 SHALL, when trap_wen_i = 1, load mepc <= trap_mepc_i & ~3, mcause <= trap_mcause_i, mstatus <= trap_mstatus_i masked per REQ-017, at the next edge.
REQ-020 SHALL give trap_wen_i priority: when trap_wen_i and csr_op_i != 00 coincide, the entire instruction write is dropped that cycle.
REQ-021 SHALL increment mcycle by 1 every cycle, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0; an accepted instruction write to mcycle loads the written value instead of incrementing that cycle.
REQ-022 SHALL register timer_irq_i into mip bit 7 (MTIP) every cycle; one-cycle latency; all other mip bits read 0.
REQ-023 SHALL register irq_pending_o from post-update state: one cycle after the enabling write or MTIP rise.
REQ-024 SHALL return pre-edge (old) value on csr_rdata_o and mtvec_o/mepc_o/mstatus_o when read and write target the same CSR in one cycle (no bypass).
REQ-025 SHALL evaluate RS/RC with wdata = 0 as a read-only access: no write, mcycle still increments.

Reset
REQ-026 SHALL, while rst = 1 at an edge, set mstatus = 64'h1800 (MPP = M), mie = 0, mtvec = 0, mscratch = 0, mepc = 0, mcause = 0, mip = 0, mcycle = 0, irq_pending_o = 0.
REQ-027 SHALL give rst priority over trap_wen_i and instruction writes; reset mid-operation discards any pending update.
REQ-028 SHALL hold mcycle at 0 for every cycle rst is high; first increment at the first edge with rst = 0.

Verification
REQ-029 SHALL cover: RW 0x305 <= 0x8000_0003 -> next cycle mtvec_o = 0x8000_0000, read of 0x305 returns same.
REQ-030 SHALL cover: mstatus = 0x1800, RS 0x300 wdata 0x8 then RC 0x300 wdata 0x1800 -> 0x1808 then 0x0008.
REQ-031 SHALL cover: same cycle trap_wen_i = 1 (mepc 0x8000_0104, mcause 11) and RW 0x341 <= 0x1234 -> mepc_o = 0x8000_0104, mcause = 11.
REQ-032 SHALL cover: RW 0xB00 <= 0xFFFF_FFFF_FFFF_FFFE -> following reads 0x...FFFF then 0 (wrap).
REQ-033 SHALL cover: mstatus.MIE = 1, mie = 0x80, timer_irq_i rises at cycle N -> mip reads 0x80 at N+1, irq_pending_o = 1 at N+2.
REQ-034 SHALL cover: read 0x7C0 -> csr_rdata_o = 0, csr_illegal_o = 1; rst asserted mid-sequence -> all values per REQ-026 next cycle.

Source files
------------

// File: rtl/csr_regs.sv
// Machine-mode CSR file: combinational read port, one instruction write port
// and a trap-controller update port that takes priority over it.
module csr_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_raddr_i,
  output logic [63:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [63:0] csr_wdata_i,
  input  logic        trap_wen_i,
  input  logic [63:0] trap_mepc_i,
  input  logic [63:0] trap_mcause_i,
  input  logic [63:0] trap_mstatus_i,
  output logic [63:0] mtvec_o,
  output logic [63:0] mepc_o,
  output logic [63:0] mstatus_o,
  input  logic        timer_irq_i,
  output logic        irq_pending_o
);

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;

  // MIE (3), MPIE (7), MPP (12:11)
  localparam logic [63:0] MSTATUS_MASK  = 64'h0000_0000_0000_1888;
  localparam logic [63:0] MSTATUS_RESET = 64'h0000_0000_0000_1800;
  localparam logic [63:0] MIE_MASK      = 64'h0000_0000_0000_0080;
  localparam logic [63:0] ALIGN4_MASK   = ~64'h3;

  logic [63:0] mstatus_q;
  logic [63:0] mie_q;
  logic [63:0] mtvec_q;
  logic [63:0] mscratch_q;
  logic [63:0] mepc_q;
  logic [63:0] mcause_q;
  logic [63:0] mcycle_q;
  logic        mtip_q;
  logic        irq_pending_q;

  csr_op_e     op;
  logic [63:0] mip_val;
  logic [63:0] wr_old;
  logic [63:0] wr_new;
  logic        wr_known;
  logic        wr_en;

  assign op      = csr_op_e'(csr_op_i);
  assign mip_val = {56'b0, mtip_q, 7'b0};

  always_comb begin
    csr_rdata_o   = '0;
    csr_illegal_o = 1'b0;
    case (csr_raddr_i)
      ADDR_MSTATUS:  csr_rdata_o = mstatus_q;
      ADDR_MIE:      csr_rdata_o = mie_q;
      ADDR_MTVEC:    csr_rdata_o = mtvec_q;
      ADDR_MSCRATCH: csr_rdata_o = mscratch_q;
      ADDR_MEPC:     csr_rdata_o = mepc_q;
      ADDR_MCAUSE:   csr_rdata_o = mcause_q;
      ADDR_MIP:      csr_rdata_o = mip_val;
      ADDR_MCYCLE:   csr_rdata_o = mcycle_q;
      default:       csr_illegal_o = 1'b1;
    endcase
  end

  // mip and unimplemented addresses are simply not writable targets
  always_comb begin
    wr_old   = '0;
    wr_known = 1'b1;
    case (csr_waddr_i)
      ADDR_MSTATUS:  wr_old = mstatus_q;
      ADDR_MIE:      wr_old = mie_q;
      ADDR_MTVEC:    wr_old = mtvec_q;
      ADDR_MSCRATCH: wr_old = mscratch_q;
      ADDR_MEPC:     wr_old = mepc_q;
      ADDR_MCAUSE:   wr_old = mcause_q;
      ADDR_MCYCLE:   wr_old = mcycle_q;
      default:       wr_known = 1'b0;
    endcase
  end

  always_comb begin
    wr_new = wr_old;
    case (op)
      OP_RW:   wr_new = csr_wdata_i;
      OP_RS:   wr_new = wr_old | csr_wdata_i;
      OP_RC:   wr_new = wr_old & ~csr_wdata_i;
      default: wr_new = wr_old;
    endcase
  end

  // Set/clear with a zero operand is a pure read and must not block mcycle
  assign wr_en = (op != OP_NONE) && wr_known && !trap_wen_i &&
                 !(((op == OP_RS) || (op == OP_RC)) && (csr_wdata_i == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q     <= MSTATUS_RESET;
      mie_q         <= '0;
      mtvec_q       <= '0;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mcycle_q      <= '0;
      mtip_q        <= 1'b0;
      irq_pending_q <= 1'b0;
    end else begin
      mtip_q        <= timer_irq_i;
      irq_pending_q <= mstatus_q[3] & mie_q[7] & mtip_q;
      mcycle_q      <= mcycle_q + 64'd1;
      if (trap_wen_i) begin
        mepc_q    <= trap_mepc_i & ALIGN4_MASK;
        mcause_q  <= trap_mcause_i;
        mstatus_q <= trap_mstatus_i & MSTATUS_MASK;
      end else if (wr_en) begin
        case (csr_waddr_i)
          ADDR_MSTATUS:  mstatus_q  <= wr_new & MSTATUS_MASK;
          ADDR_MIE:      mie_q      <= wr_new & MIE_MASK;
          ADDR_MTVEC:    mtvec_q    <= wr_new & ALIGN4_MASK;
          ADDR_MSCRATCH: mscratch_q <= wr_new;
          ADDR_MEPC:     mepc_q     <= wr_new & ALIGN4_MASK;
          ADDR_MCAUSE:   mcause_q   <= wr_new;
          ADDR_MCYCLE:   mcycle_q   <= wr_new;
          default:       ;
        endcase
      end
    end
  end

  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;
  assign mstatus_o     = mstatus_q;
  assign irq_pending_o = irq_pending_q;

endmodule

// File: tb/tb_csr_regs.sv
// Directed bench for csr_regs: stimulus queues expected outputs, a monitor
// compares them at the falling edge of the cycle they were issued in.
module tb_csr_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_raddr_i;
  logic [63:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_waddr_i;
  logic [63:0] csr_wdata_i;
  logic        trap_wen_i;
  logic [63:0] trap_mepc_i;
  logic [63:0] trap_mcause_i;
  logic [63:0] trap_mstatus_i;
  logic [63:0] mtvec_o;
  logic [63:0] mepc_o;
  logic [63:0] mstatus_o;
  logic        timer_irq_i;
  logic        irq_pending_o;

  csr_regs dut (
    .clk            (clk),
    .rst            (rst),
    .csr_raddr_i    (csr_raddr_i),
    .csr_rdata_o    (csr_rdata_o),
    .csr_illegal_o  (csr_illegal_o),
    .csr_op_i       (csr_op_i),
    .csr_waddr_i    (csr_waddr_i),
    .csr_wdata_i    (csr_wdata_i),
    .trap_wen_i     (trap_wen_i),
    .trap_mepc_i    (trap_mepc_i),
    .trap_mcause_i  (trap_mcause_i),
    .trap_mstatus_i (trap_mstatus_i),
    .mtvec_o        (mtvec_o),
    .mepc_o         (mepc_o),
    .mstatus_o      (mstatus_o),
    .timer_irq_i    (timer_irq_i),
    .irq_pending_o  (irq_pending_o)
  );

  always #5 clk = ~clk;

  localparam int SEL_RDATA   = 0;
  localparam int SEL_ILLEGAL = 1;
  localparam int SEL_MTVEC   = 2;
  localparam int SEL_MEPC    = 3;
  localparam int SEL_MSTATUS = 4;
  localparam int SEL_IRQ     = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } chk_t;

  chk_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial begin
    chk_t        c;
    logic [63:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        c = q.pop_front();
        case (c.sel)
          SEL_RDATA:   act = csr_rdata_o;
          SEL_ILLEGAL: act = {63'b0, csr_illegal_o};
          SEL_MTVEC:   act = mtvec_o;
          SEL_MEPC:    act = mepc_o;
          SEL_MSTATUS: act = mstatus_o;
          default:     act = {63'b0, irq_pending_o};
        endcase
        n_checks++;
        if (act !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    csr_op_i   = 2'b00;
    trap_wen_i = 1'b0;
  endtask

  task automatic chk(input string name, input int sel, input logic [63:0] v);
    q.push_back('{name, sel, v});
  endtask

  task automatic rd(input logic [11:0] a, input string name, input logic [63:0] v);
    csr_raddr_i = a;
    chk(name, SEL_RDATA, v);
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [63:0] d);
    csr_op_i    = op;
    csr_waddr_i = a;
    csr_wdata_i = d;
  endtask

  initial begin
    rst = 1'b1; csr_raddr_i = '0; csr_op_i = '0; csr_waddr_i = '0; csr_wdata_i = '0;
    trap_wen_i = 1'b0; trap_mepc_i = '0; trap_mcause_i = '0; trap_mstatus_i = '0;
    timer_irq_i = 1'b0;

    step(); step();
    rd(12'h300, "rst_mstatus_rd", 64'h1800);
    chk("rst_illegal", SEL_ILLEGAL, 64'd0);
    chk("rst_mstatus_o", SEL_MSTATUS, 64'h1800);
    chk("rst_mtvec_o", SEL_MTVEC, 64'd0);
    chk("rst_mepc_o", SEL_MEPC, 64'd0);
    chk("rst_irq", SEL_IRQ, 64'd0);
    step(); rd(12'hB00, "mcycle_in_rst", 64'd0);
    step(); rst = 1'b0; rd(12'hB00, "mcycle_release", 64'd0);
    step(); rd(12'hB00, "mcycle_first_inc", 64'd1);
    step(); rd(12'hB00, "mcycle_second_inc", 64'd2);

    // mtvec write, alignment, no bypass
    step(); wr(2'b01, 12'h305, 64'h8000_0003);
    rd(12'h305, "mtvec_no_bypass", 64'd0);
    chk("mtvec_o_old", SEL_MTVEC, 64'd0);
    step(); rd(12'h305, "mtvec_rd", 64'h8000_0000);
    chk("mtvec_o_new", SEL_MTVEC, 64'h8000_0000);

    // mstatus set / clear
    step(); wr(2'b10, 12'h300, 64'h8); rd(12'h300, "mstatus_pre_rs", 64'h1800);
    step(); wr(2'b11, 12'h300, 64'h1800); rd(12'h300, "mstatus_after_rs", 64'h1808);
    step(); rd(12'h300, "mstatus_after_rc", 64'h8);
    chk("mstatus_o_rc", SEL_MSTATUS, 64'h8);

    // write masks
    step(); wr(2'b01, 12'h300, '1);
    step(); wr(2'b01, 12'h304, '1); rd(12'h300, "mstatus_mask", 64'h1888);
    step(); rd(12'h304, "mie_mask", 64'h80);

    // trap beats a same-cycle instruction write
    step();
    trap_wen_i = 1'b1; trap_mepc_i = 64'h8000_0107; trap_mcause_i = 64'd11;
    trap_mstatus_i = 64'hFFFF_0000_0000_1088;
    wr(2'b01, 12'h341, 64'h1234);
    rd(12'h341, "mepc_pre_trap", 64'd0);
    step(); rd(12'h342, "trap_mcause", 64'd11);
    chk("trap_mepc_o", SEL_MEPC, 64'h8000_0104);
    chk("trap_mstatus_o", SEL_MSTATUS, 64'h1088);
    step(); wr(2'b01, 12'h341, 64'h1237);
    step(); rd(12'h341, "mepc_align", 64'h1234);

    // ignored writes: mip and unimplemented address
    step(); wr(2'b01, 12'h344, 64'hFF);
    step(); wr(2'b01, 12'h7C0, '1); rd(12'h344, "mip_write_ignored", 64'd0);
    step(); rd(12'h7C0, "illegal_rdata", 64'd0);
    chk("illegal_flag", SEL_ILLEGAL, 64'd1);

    // mscratch full width, zero-operand set/clear is a read
    step(); wr(2'b01, 12'h340, 64'hDEAD_BEEF_0123_4567);
    step(); wr(2'b10, 12'h340, 64'd0); rd(12'h340, "mscratch_rw", 64'hDEAD_BEEF_0123_4567);
    step(); wr(2'b11, 12'h340, 64'hFF00); rd(12'h340, "mscratch_rs0", 64'hDEAD_BEEF_0123_4567);
    step(); rd(12'h340, "mscratch_rc", 64'hDEAD_BEEF_0123_0067);

    // mcycle wrap, RC with zero operand still increments
    step(); wr(2'b01, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFE);
    step(); rd(12'hB00, "mcycle_loaded", 64'hFFFF_FFFF_FFFF_FFFE);
    step(); wr(2'b11, 12'hB00, 64'd0); rd(12'hB00, "mcycle_max", 64'hFFFF_FFFF_FFFF_FFFF);
    step(); rd(12'hB00, "mcycle_wrap", 64'd0);
    step(); rd(12'hB00, "mcycle_after_wrap", 64'd1);

    // timer interrupt latency (MIE=1, MTIE=1 from above)
    step(); timer_irq_i = 1'b1; rd(12'h344, "mip_n", 64'd0); chk("irq_n", SEL_IRQ, 64'd0);
    step(); rd(12'h344, "mip_n1", 64'h80); chk("irq_n1", SEL_IRQ, 64'd0);
    step(); timer_irq_i = 1'b0; rd(12'h344, "mip_n2", 64'h80); chk("irq_n2", SEL_IRQ, 64'd1);
    step(); rd(12'h344, "mip_fall", 64'd0); chk("irq_n3", SEL_IRQ, 64'd1);
    step(); timer_irq_i = 1'b1; chk("irq_clear", SEL_IRQ, 64'd0);
    step(); chk("irq_rise2_lat", SEL_IRQ, 64'd0);
    step(); chk("irq_rise2", SEL_IRQ, 64'd1);

    // reset mid-sequence with competing updates
    rst = 1'b1;
    trap_wen_i = 1'b1; trap_mepc_i = 64'h4444; trap_mcause_i = 64'd7; trap_mstatus_i = '1;
    wr(2'b01, 12'h340, 64'd5);
    step(); rst = 1'b0; timer_irq_i = 1'b0;
    rd(12'h344, "rst2_mip", 64'd0);
    chk("rst2_mstatus_o", SEL_MSTATUS, 64'h1800);
    chk("rst2_mtvec_o", SEL_MTVEC, 64'd0);
    chk("rst2_mepc_o", SEL_MEPC, 64'd0);
    chk("rst2_irq", SEL_IRQ, 64'd0);
    step(); rd(12'hB00, "rst2_mcycle", 64'd1);
    step(); rd(12'h340, "rst2_mscratch", 64'd0);
    step(); rd(12'h342, "rst2_mcause", 64'd0);
    step(); rd(12'h304, "rst2_mie", 64'd0);
    step(); rd(12'h300, "rst2_mstatus_rd", 64'h1800);

    step();
    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d checks left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
